// File: rtl/dma_xfer_ctrl_if.sv
// Bus and FIFO strobe bundle between the DMA transfer sequencer and its
// shared single-beat memory port / data FIFO.
interface dma_xfer_ctrl_if #(
    parameter int padd_size = 24
);
    logic                 mem_req;
    logic                 mem_we;
    logic [padd_size-1:0] mem_addr;
    logic                 mem_ack;
    logic                 fifo_wr;
    logic                 fifo_rd;

    // Sequencer side: issues beats and FIFO strobes, receives acknowledge.
    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        input  mem_ack,
        output fifo_wr,
        output fifo_rd
    );

    // Memory/FIFO side: observes beats and strobes, returns acknowledge.
    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        output mem_ack,
        input  fifo_wr,
        input  fifo_rd
    );
endinterface

// File: rtl/dma_xfer_ctrl.sv
// dma_xfer_ctrl: DMA transfer sequencer. Alternates a read phase that fills
// the FIFO from memory with a write phase that drains it back to memory,
// one single-beat bus transaction at a time, until the length is used up.
module dma_xfer_ctrl #(
    parameter int padd_size = 24,
    parameter int data_size = 32,
    parameter int FIFO_AW   = 4
) (
    input  logic                 clk0,
    input  logic                 reset_n,
    input  logic                 go,
    input  logic [2:0]           size,
    input  logic [padd_size-1:0] rd_addr_in,
    input  logic [padd_size-1:0] wr_addr_in,
    input  logic [data_size-1:0] len_in,
    dma_xfer_ctrl_if.master      bus,
    output logic                 busy,
    output logic                 done,
    output logic                 reop,
    output logic                 weop,
    output logic                 err,
    output logic [data_size-1:0] remaining
);

    // Occupancy reaching this value means the FIFO is full.
    localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_PUSH,
        WR_POP,
        WR_REQ,
        DONE
    } state_t;

    state_t               state;
    logic [padd_size-1:0] rd_addr;
    logic [padd_size-1:0] wr_addr;
    logic [data_size-1:0] rd_rem;
    logic [data_size-1:0] wr_rem;
    logic [FIFO_AW:0]     occ;
    logic [2:0]           step;

    logic [padd_size-1:0] rd_addr_nxt;
    logic [padd_size-1:0] wr_addr_nxt;
    logic [data_size-1:0] rd_rem_nxt;
    logic [data_size-1:0] wr_rem_nxt;
    logic [FIFO_AW:0]     occ_inc;

    // Exactly one of byte / half-word / word must be selected.
    function automatic logic size_ok(input logic [2:0] s);
        return (s == 3'b001) || (s == 3'b010) || (s == 3'b100);
    endfunction

    // Bytes per beat for a (valid) one-hot size code.
    function automatic logic [2:0] step_of(input logic [2:0] s);
        case (s)
            3'b001:  return 3'd1;
            3'b010:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Decrement by one beat, saturating at zero for a short final beat.
    function automatic logic [data_size-1:0] sat_dec(input logic [data_size-1:0] rem,
                                                     input logic [2:0]           st);
        if (rem < data_size'(st)) return '0;
        else                      return rem - data_size'(st);
    endfunction

    // Post-beat values; address arithmetic wraps naturally at padd_size bits.
    assign rd_addr_nxt = rd_addr + padd_size'(step);
    assign wr_addr_nxt = wr_addr + padd_size'(step);
    assign rd_rem_nxt  = sat_dec(rd_rem, step);
    assign wr_rem_nxt  = sat_dec(wr_rem, step);
    assign occ_inc     = occ + 1'b1;
    assign remaining   = wr_rem;

    // Sequencer FSM: all bus, strobe and status outputs are registered here.
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rd_addr      <= '0;
            wr_addr      <= '0;
            rd_rem       <= '0;
            wr_rem       <= '0;
            occ          <= '0;
            step         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            reop         <= 1'b0;
            weop         <= 1'b0;
            err          <= 1'b0;
            bus.mem_req  <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.fifo_wr  <= 1'b0;
            bus.fifo_rd  <= 1'b0;
        end else begin
            bus.fifo_wr <= 1'b0;
            bus.fifo_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        if (!size_ok(size)) begin
                            err <= 1'b1;
                        end else if (len_in == '0) begin
                            // Nothing to move: report completion without touching the bus.
                            done <= 1'b1;
                            err  <= 1'b0;
                        end else begin
                            rd_addr      <= rd_addr_in;
                            wr_addr      <= wr_addr_in;
                            rd_rem       <= len_in;
                            wr_rem       <= len_in;
                            occ          <= '0;
                            step         <= step_of(size);
                            done         <= 1'b0;
                            reop         <= 1'b0;
                            weop         <= 1'b0;
                            err          <= 1'b0;
                            busy         <= 1'b1;
                            bus.mem_req  <= 1'b1;
                            bus.mem_we   <= 1'b0;
                            bus.mem_addr <= rd_addr_in;
                            state        <= RD_REQ;
                        end
                    end
                end

                RD_REQ: begin
                    // Request stays up until acknowledged, even when aborting.
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        if (!go) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            bus.fifo_wr <= 1'b1;
                            state       <= RD_PUSH;
                        end
                    end
                end

                RD_PUSH: begin
                    occ     <= occ_inc;
                    rd_addr <= rd_addr_nxt;
                    rd_rem  <= rd_rem_nxt;
                    if (rd_rem_nxt == '0) reop <= 1'b1;
                    if (!go) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if ((occ_inc < DEPTH) && (rd_rem_nxt != '0)) begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= rd_addr_nxt;
                        state        <= RD_REQ;
                    end else begin
                        // FIFO full or read side exhausted: switch to draining.
                        bus.fifo_rd <= 1'b1;
                        state       <= WR_POP;
                    end
                end

                WR_POP: begin
                    occ <= occ - 1'b1;
                    if (!go) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b1;
                        bus.mem_addr <= wr_addr;
                        state        <= WR_REQ;
                    end
                end

                WR_REQ: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        wr_addr     <= wr_addr_nxt;
                        wr_rem      <= wr_rem_nxt;
                        if (wr_rem_nxt == '0) begin
                            // Last beat finished: completion wins over a late abort.
                            weop  <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (!go) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (occ != '0) begin
                            bus.fifo_rd <= 1'b1;
                            state       <= WR_POP;
                        end else begin
                            // FIFO drained with data still to read: refill.
                            bus.mem_req  <= 1'b1;
                            bus.mem_we   <= 1'b0;
                            bus.mem_addr <= rd_addr;
                            state        <= RD_REQ;
                        end
                    end
                end

                DONE: begin
                    if (!go) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Bench for dma_xfer_ctrl: directed and randomized transfers checked against
// a beat-list reference model, plus abort, error, zero-length and reset cases.
module tb_dma_xfer_ctrl;

    logic        clk0       = 1'b0;
    logic        reset_n    = 1'b0;
    logic        go         = 1'b0;
    logic [2:0]  size       = 3'b000;
    logic [23:0] rd_addr_in = '0;
    logic [23:0] wr_addr_in = '0;
    logic [31:0] len_in     = '0;
    logic        busy, done, reop, weop, err;
    logic [31:0] remaining;

    int total   = 0;
    int bad     = 0;
    int ack_dly = 0;
    int wcnt;

    dma_xfer_ctrl_if bus ();

    dma_xfer_ctrl dut (
        .clk0       (clk0),
        .reset_n    (reset_n),
        .go         (go),
        .size       (size),
        .rd_addr_in (rd_addr_in),
        .wr_addr_in (wr_addr_in),
        .len_in     (len_in),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .reop       (reop),
        .weop       (weop),
        .err        (err),
        .remaining  (remaining)
    );

    always #5 clk0 = ~clk0;

    // Memory responder: acknowledges after ack_dly cycles of request.
    assign bus.mem_ack = bus.mem_req && (wcnt >= ack_dly);

    always @(posedge clk0 or negedge reset_n) begin
        if (!reset_n)                         wcnt <= 0;
        else if (!bus.mem_req || bus.mem_ack) wcnt <= 0;
        else                                  wcnt <= wcnt + 1;
    end

    // Observation log, filled by tick() on every falling edge.
    logic        q_we[$];
    logic [23:0] q_addr[$];
    logic [31:0] rem_log[$];
    int          n_wr, n_rd, occ_m, peak, occ_viol, drop_viol, stab_viol;
    logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [23:0] p_addr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk0);
        if (reset_n) begin
            if (bus.mem_req && bus.mem_ack) begin
                q_we.push_back(bus.mem_we);
                q_addr.push_back(bus.mem_addr);
            end
            if (p_req && !p_ack && !bus.mem_req) drop_viol++;
            if (p_req && !p_ack && bus.mem_req &&
                ((bus.mem_addr !== p_addr) || (bus.mem_we !== p_we))) stab_viol++;
            if (bus.fifo_wr) begin n_wr++; occ_m++; end
            if (bus.fifo_rd) begin n_rd++; occ_m--; rem_log.push_back(remaining); end
            if (occ_m > peak) peak = occ_m;
            if (occ_m < 0 || occ_m > 16) occ_viol++;
            p_req  = bus.mem_req;
            p_ack  = bus.mem_ack;
            p_we   = bus.mem_we;
            p_addr = bus.mem_addr;
        end else begin
            p_req = 1'b0;
            p_ack = 1'b0;
        end
    endtask

    task automatic clear_logs();
        q_we.delete();
        q_addr.delete();
        rem_log.delete();
        n_wr = 0; n_rd = 0; occ_m = 0; peak = 0;
        occ_viol = 0; drop_viol = 0; stab_viol = 0;
    endtask

    // Full transfer: start, wait for completion, compare with the beat model.
    task automatic run_xfer(input string nm, input logic [2:0] sz, input logic [31:0] len,
                            input logic [23:0] rd, input logic [23:0] wr, input int dly);
        int          stp, nb, cnt, c, base, pk;
        logic        exp_we[$];
        logic [23:0] exp_addr[$];
        clear_logs();
        ack_dly    = dly;
        size       = sz;
        len_in     = len;
        rd_addr_in = rd;
        wr_addr_in = wr;
        go         = 1'b1;
        cnt = 0;
        do begin tick(); cnt++; end while (!(done && !busy) && cnt < 4000);
        chk({nm, "_timeout"}, (cnt >= 4000), 0);

        // Model: ceil(len/step) beats, in chunks of at most 16 reads then as many writes.
        stp  = (sz == 3'b001) ? 1 : (sz == 3'b010) ? 2 : 4;
        nb   = (int'(len) + stp - 1) / stp;
        base = 0;
        while (base < nb) begin
            c = (nb - base > 16) ? 16 : nb - base;
            for (int i = 0; i < c; i++) begin
                exp_we.push_back(1'b0);
                exp_addr.push_back(rd + 24'((base + i) * stp));
            end
            for (int i = 0; i < c; i++) begin
                exp_we.push_back(1'b1);
                exp_addr.push_back(wr + 24'((base + i) * stp));
            end
            base += c;
        end
        pk = (nb > 16) ? 16 : nb;

        chk({nm, "_beats"}, q_we.size(), exp_we.size());
        for (int i = 0; i < exp_we.size() && i < q_we.size(); i++) begin
            chk($sformatf("%s_b%0d_we", nm, i), q_we[i], exp_we[i]);
            chk($sformatf("%s_b%0d_addr", nm, i), q_addr[i], exp_addr[i]);
        end
        chk({nm, "_fifo_wr"}, n_wr, nb);
        chk({nm, "_fifo_rd"}, n_rd, nb);
        chk({nm, "_occ_peak"}, peak, pk);
        chk({nm, "_occ_range"}, occ_viol, 0);
        chk({nm, "_req_drop"}, drop_viol, 0);
        chk({nm, "_req_stable"}, stab_viol, 0);
        chk({nm, "_rem_n"}, rem_log.size(), nb);
        for (int i = 0; i < nb && i < rem_log.size(); i++)
            chk($sformatf("%s_rem%0d", nm, i), rem_log[i], len - 32'(i * stp));
        chk({nm, "_reop"}, reop, 1);
        chk({nm, "_weop"}, weop, 1);
        chk({nm, "_done"}, done, 1);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_remaining"}, remaining, 0);
        go = 1'b0;
        tick();
        tick();
        chk({nm, "_done_sticky"}, done, 1);
        chk({nm, "_idle_req"}, bus.mem_req, 0);
    endtask

    initial begin
        int cnt;

        // Reset state
        clear_logs();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_reop", reop, 0);
        chk("rst_weop", weop, 0);
        chk("rst_err", err, 0);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_fifo_wr", bus.fifo_wr, 0);
        chk("rst_fifo_rd", bus.fifo_rd, 0);
        chk("rst_remaining", remaining, 0);

        // Word, len 8, same-cycle ack
        run_xfer("word8", 3'b100, 32'd8, 24'h000100, 24'h000200, 0);
        chk("word8_rd1", q_addr[1], 24'h000104);
        chk("word8_wr1", q_addr[3], 24'h000204);

        // Byte, len 20: 16/16 then 4/4
        run_xfer("byte20", 3'b001, 32'd20, 24'h001000, 24'h002000, 1);

        // Half-word, len 5: remaining 5, 3, 1, 0
        run_xfer("hw5", 3'b010, 32'd5, 24'h000300, 24'h000400, 2);

        // Write address wraps past the top of the address space
        run_xfer("wrap", 3'b100, 32'd8, 24'h000010, 24'hFFFFFC, 0);
        chk("wrap_wr0", q_addr[2], 24'hFFFFFC);
        chk("wrap_wr1", q_addr[3], 24'h000000);

        // Abort during RD_REQ with a slow acknowledge
        clear_logs();
        ack_dly    = 3;
        size       = 3'b100;
        len_in     = 32'd8;
        rd_addr_in = 24'h000500;
        wr_addr_in = 24'h000600;
        go         = 1'b1;
        cnt = 0;
        do begin tick(); cnt++; end while (!bus.mem_req && cnt < 20);
        chk("abort_req_seen", bus.mem_req, 1);
        go = 1'b0;
        cnt = 0;
        do begin tick(); cnt++; end while (busy && cnt < 20);
        chk("abort_timeout", (cnt >= 20), 0);
        chk("abort_beats", q_we.size(), 1);
        chk("abort_beat_addr", q_addr[0], 24'h000500);
        chk("abort_req_drop", drop_viol, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (5) tick();
        chk("abort_quiet", q_we.size(), 1);
        chk("abort_req_low", bus.mem_req, 0);

        // Invalid size rejected, then a valid size starts the transfer
        clear_logs();
        ack_dly = 0;
        size    = 3'b011;
        len_in  = 32'd8;
        go      = 1'b1;
        repeat (3) tick();
        chk("err_set", err, 1);
        chk("err_busy", busy, 0);
        chk("err_no_beats", q_we.size(), 0);
        run_xfer("err_recover", 3'b100, 32'd8, 24'h000700, 24'h000800, 0);

        // Zero length: done at once, no bus traffic
        clear_logs();
        size   = 3'b001;
        len_in = 32'd0;
        go     = 1'b1;
        tick();
        tick();
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_beats", q_we.size(), 0);
        chk("len0_req", bus.mem_req, 0);
        go = 1'b0;
        tick();

        // Randomized transfers
        for (int r = 0; r < 10; r++) begin
            logic [2:0] rs;
            rs = 3'b001 << $urandom_range(0, 2);
            run_xfer($sformatf("rnd%0d", r), rs, 32'($urandom_range(1, 40)),
                     24'($urandom), 24'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a transfer
        clear_logs();
        ack_dly    = 1;
        size       = 3'b001;
        len_in     = 32'd20;
        rd_addr_in = 24'h000900;
        wr_addr_in = 24'h000A00;
        go         = 1'b1;
        repeat (15) tick();
        chk("midrst_active", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_req", bus.mem_req, 0);
        chk("midrst_fifo_wr", bus.fifo_wr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_remaining", remaining, 0);
        chk("midrst_addr", bus.mem_addr, 0);
        go = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        run_xfer("post_rst", 3'b010, 32'd12, 24'h000B00, 24'h000C00, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
